step_pulse_gen: RTL and testbench

Converts the slow, button-driven toggle produced by the manual clock stage into single-cycle step enables in the system clock domain. It also provides a free-running mode with a fixed period. The pipeline CPU uses its `step_en` output as a global advance enable, so the core runs on the fast board clock while advancing one step per button press. A step counter is exposed for the debug display.

---
 rtl/step_pulse_gen.sv | 114 +++++++++++
 tb/tb_step_pulse_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Turns manual-clock toggles into one-cycle step enables in the system clock domain.
// In run mode it instead issues a step every RUN_DIV cycles, and it counts every step issued.
module step_pulse_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int RUN_DIV     = 50_000_000,
  parameter int COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               signal,
  input  logic               run_mode,
  input  logic               halt,
  input  logic               clear_count,
  output logic               step_en,
  output logic [COUNT_W-1:0] step_count,
  output logic               running
);

  localparam int WARM   = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM + 1);
  localparam int DIV_W  = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic                 press_q;
  logic [WARM_W-1:0]    warm_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 step_d;
  logic [COUNT_W-1:0]   count_d;

  logic sync_out;
  logic warm_done;
  logic press_ev;
  logic div_last;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_W'(WARM));
  assign press_ev  = warm_done && (sync_out != prev_q);
  assign div_last  = (div_q == DIV_W'(RUN_DIV - 1));

  // Presses are only latched in IDLE, so a press seen during RUN or halt never fires after exit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      warm_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], signal};
      prev_q  <= sync_out;
      press_q <= press_ev && (state_q == IDLE) && !halt;
      if (!warm_done) warm_q <= warm_q + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = 1'b0;
    if (halt) begin
      state_d = IDLE;
      div_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          step_d = press_q;
          if (run_mode) begin
            state_d = RUN;
            div_d   = '0;
          end
        end
        RUN: begin
          if (!run_mode) begin
            state_d = IDLE;
            div_d   = '0;
          end else begin
            step_d = div_last;
            div_d  = div_last ? '0 : div_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A step and a clear in the same cycle leave the count at one.
  always_comb begin
    count_d = step_count;
    if (step_d)           count_d = clear_count ? COUNT_W'(1) : step_count + 1'b1;
    else if (clear_count) count_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      step_en    <= 1'b0;
      step_count <= '0;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      step_en    <= step_d;
      step_count <= count_d;
      running    <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: a vector table for press and run-mode behaviour,
// then hand-written sequences for halt, counter wrap/clear and reset corner cases.
module tb_step_pulse_gen;

  localparam int COUNT_W = 3;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               signal;
  logic               run_mode;
  logic               halt;
  logic               clear_count;
  logic               step_en;
  logic [COUNT_W-1:0] step_count;
  logic               running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sig;
    logic       run;
    logic       hlt;
    logic       clr;
    logic       exp_step;
    logic [2:0] exp_count;
    logic       exp_running;
  } vec_t;

  vec_t vecs[$];

  step_pulse_gen #(
    .SYNC_STAGES(2),
    .RUN_DIV    (4),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .signal     (signal),
    .run_mode   (run_mode),
    .halt       (halt),
    .clear_count(clear_count),
    .step_en    (step_en),
    .step_count (step_count),
    .running    (running)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic s, input logic [2:0] c, input logic r);
    check({tag, ".step_en"},    32'(step_en),    32'(s));
    check({tag, ".step_count"}, 32'(step_count), 32'(c));
    check({tag, ".running"},    32'(running),    32'(r));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic sg, input logic rn, input logic hl, input logic cl,
                     input logic es, input logic [2:0] ec, input logic er, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{sg, rn, hl, cl, es, ec, er});
  endtask

  initial begin
    // Manual presses after warm-up, then run mode with a toggle during RUN and an exit at divider wrap.
    add(0, 0, 0, 0, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 1, 2, 0, 1);
    add(0, 0, 0, 0, 0, 2, 0, 1);
    add(0, 1, 0, 0, 0, 2, 1, 4);
    add(0, 1, 0, 0, 1, 3, 1, 1);
    add(1, 1, 0, 0, 0, 3, 1, 3);
    add(1, 1, 0, 0, 1, 4, 1, 1);
    add(1, 1, 0, 0, 0, 4, 1, 3);
    add(1, 1, 0, 0, 1, 5, 1, 1);
    add(1, 1, 0, 0, 0, 5, 1, 2);
    add(1, 0, 0, 0, 0, 5, 0, 4);

    reset_n = 1'b0; signal = 1'b0; run_mode = 1'b0; halt = 1'b0; clear_count = 1'b0;
    #1;
    check_outs("reset", 1'b0, 3'd0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      signal      = vecs[i].sig;
      run_mode    = vecs[i].run;
      halt        = vecs[i].hlt;
      clear_count = vecs[i].clr;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_step, vecs[i].exp_count, vecs[i].exp_running);
    end

    // Halt asserted at divider=3 suppresses the pulse; release re-enters RUN with a fresh period.
    run_mode = 1'b1;
    tick(); check_outs("halt.enter", 1'b0, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check_outs($sformatf("halt.div%0d", i + 1), 1'b0, 3'd5, 1'b1);
    end
    halt = 1'b1;
    tick(); check_outs("halt.at_div3", 1'b0, 3'd5, 1'b0);
    tick(); check_outs("halt.hold", 1'b0, 3'd5, 1'b0);
    halt = 1'b0;
    tick(); check_outs("halt.rerise", 1'b0, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check_outs($sformatf("halt.wait%0d", i), 1'b0, 3'd5, 1'b1);
    end
    tick(); check_outs("halt.first_pulse", 1'b1, 3'd6, 1'b1);

    // Clear without a step, then eight run pulses wrap the 3-bit counter back to zero.
    clear_count = 1'b1;
    tick(); check_outs("clear.no_step", 1'b0, 3'd0, 1'b1);
    clear_count = 1'b0;
    repeat (2) begin
      tick(); check_outs("wrap.pre", 1'b0, 3'd0, 1'b1);
    end
    for (int p = 0; p < 8; p++) begin
      tick(); check_outs($sformatf("wrap.pulse%0d", p), 1'b1, 3'((p + 1) % 8), 1'b1);
      for (int k = 0; k < 3; k++) begin
        tick(); check_outs($sformatf("wrap.gap%0d_%0d", p, k), 1'b0, 3'((p + 1) % 8), 1'b1);
      end
    end
    clear_count = 1'b1;
    tick(); check_outs("clear.with_step", 1'b1, 3'd1, 1'b1);
    clear_count = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); check_outs($sformatf("post_clear%0d", k), 1'b0, 3'd1, 1'b1);
    end

    // Async reset while step_en is high must clear outputs before the next edge.
    tick(); check_outs("pre_reset_pulse", 1'b1, 3'd2, 1'b1);
    #1 reset_n = 1'b0;
    #1 check_outs("async_reset", 1'b0, 3'd0, 1'b0);

    // Reset released with signal held at 1: warm-up must mask the apparent edge.
    run_mode = 1'b0;
    signal   = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); check_outs($sformatf("sig1_reset%0d", i), 1'b0, 3'd0, 1'b0);
    end
    signal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_outs($sformatf("late_press.wait%0d", i), 1'b0, 3'd0, 1'b0);
    end
    tick(); check_outs("late_press.pulse", 1'b1, 3'd1, 1'b0);
    tick(); check_outs("late_press.after", 1'b0, 3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
